// File: rtl/cotm32_csr_unit.sv
// Machine-mode CSR file and trap-state sequencer for the cotm32 RV32 core:
// Zicsr access, trap entry/MRET bookkeeping and the mcycle/minstret counters.
module cotm32_csr_unit #(
    parameter int                XLEN        = 32,
    parameter int                CNT_WIDTH   = 64,
    parameter logic [XLEN-1:0]   MTVEC_RESET = '0,
    parameter logic [XLEN-1:0]   MISA_VALUE  = 32'h4000_0100
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_csr_en,
    input  logic [2:0]           i_csr_funct3,
    input  logic [11:0]          i_csr_addr,
    input  logic [XLEN-1:0]      i_csr_wdata,
    input  logic                 i_csr_src_zero,
    output logic [XLEN-1:0]      o_csr_rdata,
    output logic                 o_csr_illegal,
    input  logic                 i_trap_valid,
    input  logic [XLEN-1:0]      i_trap_cause,
    input  logic [XLEN-1:0]      i_trap_pc,
    input  logic [XLEN-1:0]      i_trap_tval,
    input  logic                 i_mret,
    input  logic                 i_instret,
    input  logic                 i_irq_ext,
    output logic                 o_irq_pending,
    output logic [XLEN-1:0]      o_mtvec,
    output logic [XLEN-1:0]      o_mepc
);
    localparam int                HI_W       = CNT_WIDTH - 32;
    localparam logic [XLEN-1:0]   ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA     = 12'h301, A_MIE    = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305, A_MSCRATCH = 12'h340, A_MEPC   = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342, A_MTVAL    = 12'h343, A_MIP    = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00, A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02, A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00, A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02, A_INSTRETH = 12'hC82;

    localparam logic [1:0] OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

    logic                 r_mie, r_mpie, r_meie;
    logic [XLEN-1:0]      r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [CNT_WIDTH-1:0] r_mcycle, r_minstret;

    logic                 w_hit;
    logic [XLEN-1:0]      w_old;
    logic [1:0]           w_op;
    logic                 w_wants_write;
    logic                 w_illegal;
    logic                 w_wr;
    logic [XLEN-1:0]      w_new;

    // Read mux: current (pre-write) value of the addressed CSR and whether it is mapped.
    always_comb begin
        w_hit = 1'b1;
        w_old = '0;
        case (i_csr_addr)
            A_MSTATUS: begin
                w_old[3]     = r_mie;
                w_old[7]     = r_mpie;
                w_old[12:11] = 2'b11;
            end
            A_MISA:                 w_old = MISA_VALUE;
            A_MIE:                  w_old[11] = r_meie;
            A_MTVEC:                w_old = r_mtvec;
            A_MSCRATCH:             w_old = r_mscratch;
            A_MEPC:                 w_old = r_mepc;
            A_MCAUSE:               w_old = r_mcause;
            A_MTVAL:                w_old = r_mtval;
            A_MIP:                  w_old[11] = i_irq_ext;
            A_MCYCLE, A_CYCLE:      w_old = r_mcycle[31:0];
            A_MCYCLEH, A_CYCLEH:    w_old[HI_W-1:0] = r_mcycle[CNT_WIDTH-1:32];
            A_MINSTRET, A_INSTRET:  w_old = r_minstret[31:0];
            A_MINSTRETH, A_INSTRETH: w_old[HI_W-1:0] = r_minstret[CNT_WIDTH-1:32];
            default:                w_hit = 1'b0;
        endcase
    end

    // Operation decode, legality and the value a committed write would store.
    always_comb begin
        case (i_csr_funct3)
            3'b001, 3'b101: w_op = OP_RW;
            3'b010, 3'b110: w_op = OP_RS;
            3'b011, 3'b111: w_op = OP_RC;
            default:        w_op = OP_NONE;
        endcase
        // Set/clear with a zero source is a pure read, so it stays legal on read-only CSRs.
        w_wants_write = (w_op == OP_RW) || ((w_op != OP_NONE) && !i_csr_src_zero);
        w_illegal = i_csr_en && ((w_op == OP_NONE) || !w_hit ||
                                 (w_wants_write && (i_csr_addr[11:10] == 2'b11)));
        w_wr = i_csr_en && !w_illegal && w_wants_write && !i_trap_valid;
        case (w_op)
            OP_RW:   w_new = i_csr_wdata;
            OP_RS:   w_new = w_old | i_csr_wdata;
            OP_RC:   w_new = w_old & ~i_csr_wdata;
            default: w_new = w_old;
        endcase
    end

    assign o_csr_illegal = w_illegal;
    assign o_csr_rdata   = w_illegal ? '0 : w_old;
    assign o_irq_pending = r_mie & r_meie & i_irq_ext;
    assign o_mtvec       = r_mtvec;
    assign o_mepc        = r_mepc;

    // State update; later assignments win, giving trap > mret > CSR write > counter increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_meie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET & ALIGN_MASK;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mcycle <= r_mcycle + CNT_ONE;
            if (i_instret) begin
                r_minstret <= r_minstret + CNT_ONE;
            end
            if (w_wr) begin
                case (i_csr_addr)
                    A_MSTATUS: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                    end
                    A_MIE:       r_meie     <= w_new[11];
                    A_MTVEC:     r_mtvec    <= w_new & ALIGN_MASK;
                    A_MSCRATCH:  r_mscratch <= w_new;
                    A_MEPC:      r_mepc     <= w_new & ALIGN_MASK;
                    A_MCAUSE:    r_mcause   <= w_new;
                    A_MTVAL:     r_mtval    <= w_new;
                    A_MCYCLE:    r_mcycle   <= {r_mcycle[CNT_WIDTH-1:32], w_new};
                    A_MCYCLEH:   r_mcycle   <= {w_new[HI_W-1:0], r_mcycle[31:0]};
                    A_MINSTRET:  r_minstret <= {r_minstret[CNT_WIDTH-1:32], w_new};
                    A_MINSTRETH: r_minstret <= {w_new[HI_W-1:0], r_minstret[31:0]};
                    default:     r_mscratch <= r_mscratch;
                endcase
            end
            if (i_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end
            if (i_trap_valid) begin
                r_mepc   <= i_trap_pc & ALIGN_MASK;
                r_mcause <= i_trap_cause;
                r_mtval  <= i_trap_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cotm32_csr_unit.sv
// Directed bench for cotm32_csr_unit: expectations are queued with a due step
// when stimulus is driven and compared when that step's outputs are sampled.
module tb_cotm32_csr_unit;
    localparam logic [2:0] F_RW = 3'b001, F_RS = 3'b010, F_RC = 3'b011;
    localparam logic [2:0] F_RSI = 3'b110, F_RCI = 3'b111;
    localparam int S_RDATA = 0, S_ILL = 1, S_IRQ = 2, S_MTVEC = 3, S_MEPC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_src_zero;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret, instret, irq_ext;
    logic        irq_pending;
    logic [31:0] mtvec_o, mepc_o;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
        int unsigned due;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned step = 0;
    int          checks = 0;
    int          failures = 0;

    cotm32_csr_unit #(
        .XLEN(32), .CNT_WIDTH(64), .MTVEC_RESET(32'h0000_0103), .MISA_VALUE(32'h4000_0100)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_csr_en(csr_en), .i_csr_funct3(csr_funct3),
        .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata), .i_csr_src_zero(csr_src_zero),
        .o_csr_rdata(csr_rdata), .o_csr_illegal(csr_illegal), .i_trap_valid(trap_valid),
        .i_trap_cause(trap_cause), .i_trap_pc(trap_pc), .i_trap_tval(trap_tval),
        .i_mret(mret), .i_instret(instret), .i_irq_ext(irq_ext),
        .o_irq_pending(irq_pending), .o_mtvec(mtvec_o), .o_mepc(mepc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_RDATA: return csr_rdata;
            S_ILL:   return {31'd0, csr_illegal};
            S_IRQ:   return {31'd0, irq_pending};
            S_MTVEC: return mtvec_o;
            S_MEPC:  return mepc_o;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(string tag, int sel, logic [31:0] exp, int unsigned dly);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        e.due = step + dly;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         keep[$];
        sb_t         e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.due <= step) begin
                obs = observe(e.sel);
                checks++;
                assert (obs === e.exp) else begin
                    failures++;
                    $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
                end
            end else begin
                keep.push_back(e);
            end
        end
        sb_q = keep;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        step++;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic op(logic [2:0] f3, logic [11:0] a, logic [31:0] wd, logic sz);
        csr_en       = 1'b1;
        csr_funct3   = f3;
        csr_addr     = a;
        csr_wdata    = wd;
        csr_src_zero = sz;
    endtask

    task automatic nop();
        csr_en       = 1'b0;
        csr_funct3   = 3'b000;
        csr_addr     = 12'h000;
        csr_wdata    = 32'd0;
        csr_src_zero = 1'b0;
    endtask

    task automatic rd(string tag, logic [2:0] f3, logic [11:0] a, logic [31:0] wd, logic sz,
                      logic [31:0] exp_rd, logic exp_ill);
        op(f3, a, wd, sz);
        push({tag, "_rdata"}, S_RDATA, exp_rd, 0);
        push({tag, "_illegal"}, S_ILL, {31'd0, exp_ill}, 0);
        settle();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        trap_valid = 1'b0; trap_cause = 32'd0; trap_pc = 32'd0; trap_tval = 32'd0;
        mret = 1'b0; instret = 1'b0; irq_ext = 1'b1;
        tick();
        tick();

        // Reset state
        push("rst_mtvec", S_MTVEC, 32'h0000_0100, 0);
        push("rst_mepc", S_MEPC, 32'd0, 0);
        push("rst_irq", S_IRQ, 32'd0, 0);
        rd("rst_mstatus", F_RS, 12'h300, 32'd0, 1'b1, 32'h0000_1800, 1'b0);
        rd("rst_mip", F_RS, 12'h344, 32'd0, 1'b1, 32'h0000_0800, 1'b0);
        rd("rst_mcycle", F_RS, 12'hB00, 32'd0, 1'b1, 32'd0, 1'b0);
        nop();
        rst = 1'b0;
        repeat (4) tick();

        // Counter read after four cycles, illegal decodes
        rd("t1_mcycle", F_RS, 12'hB00, 32'd0, 1'b1, 32'd4, 1'b0);
        rd("t1_cycleh", F_RS, 12'hC80, 32'd0, 1'b1, 32'd0, 1'b0);
        rd("t1_unmapped", F_RS, 12'h7C0, 32'd0, 1'b1, 32'd0, 1'b1);
        rd("t1_f3_000", 3'b000, 12'h300, 32'd0, 1'b0, 32'd0, 1'b1);
        rd("t1_f3_100", 3'b100, 12'h300, 32'd0, 1'b0, 32'd0, 1'b1);
        nop();
        tick();

        // mtvec write with low bits set
        push("t2_mtvec_next", S_MTVEC, 32'h0000_1000, 1);
        rd("t2_mtvec_old", F_RW, 12'h305, 32'h0000_1003, 1'b0, 32'h0000_0100, 1'b0);
        tick();
        rd("t2_mtvec_rd", F_RS, 12'h305, 32'd0, 1'b1, 32'h0000_1000, 1'b0);
        rd("misa_w", F_RW, 12'h301, 32'd0, 1'b0, 32'h4000_0100, 1'b0);
        tick();
        rd("misa_after", F_RS, 12'h301, 32'd0, 1'b1, 32'h4000_0100, 1'b0);
        rd("mip_w", F_RW, 12'h344, 32'd0, 1'b0, 32'h0000_0800, 1'b0);
        tick();
        rd("mie_w", F_RW, 12'h304, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        tick();
        push("irq_mie_off", S_IRQ, 32'd0, 0);
        rd("mie_rd", F_RS, 12'h304, 32'd0, 1'b1, 32'h0000_0800, 1'b0);

        // mscratch RW / RS / RC / RSI with zero source
        rd("scr_rw", F_RW, 12'h340, 32'h0000_F0F0, 1'b0, 32'd0, 1'b0);
        tick();
        rd("scr_rs", F_RS, 12'h340, 32'h0000_0F00, 1'b0, 32'h0000_F0F0, 1'b0);
        tick();
        rd("scr_rc", F_RC, 12'h340, 32'h0000_00F0, 1'b0, 32'h0000_FFF0, 1'b0);
        tick();
        rd("scr_rsi_z", F_RSI, 12'h340, 32'h0000_0001, 1'b1, 32'h0000_FF00, 1'b0);
        tick();
        rd("scr_keep", F_RS, 12'h340, 32'd0, 1'b1, 32'h0000_FF00, 1'b0);
        push("mepc_align", S_MEPC, 32'h0000_0330, 1);
        rd("mepc_w", F_RW, 12'h341, 32'h0000_0333, 1'b0, 32'd0, 1'b0);
        tick();

        // Interrupt pending, trap entry with a dropped CSR write
        rd("t3_set_mie", F_RS, 12'h300, 32'h0000_0008, 1'b0, 32'h0000_1800, 1'b0);
        tick();
        push("t3_irq_on", S_IRQ, 32'd1, 0);
        rd("t3_mstatus", F_RS, 12'h300, 32'd0, 1'b1, 32'h0000_1808, 1'b0);
        trap_valid = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_0124;
        trap_tval = 32'h0000_0055;
        op(F_RW, 12'h340, 32'h0000_DEAD, 1'b0);
        push("t3_mepc", S_MEPC, 32'h0000_0124, 1);
        push("t3_irq_off", S_IRQ, 32'd0, 1);
        tick();
        trap_valid = 1'b0;
        rd("t3_mstatus_trap", F_RS, 12'h300, 32'd0, 1'b1, 32'h0000_1880, 1'b0);
        rd("t3_mcause", F_RS, 12'h342, 32'd0, 1'b1, 32'h8000_000B, 1'b0);
        rd("t3_mtval", F_RS, 12'h343, 32'd0, 1'b1, 32'h0000_0055, 1'b0);
        rd("t3_scr_dropped", F_RS, 12'h340, 32'd0, 1'b1, 32'h0000_FF00, 1'b0);
        nop();

        // MRET, then trap and MRET together
        mret = 1'b1;
        tick();
        mret = 1'b0;
        push("t4_irq_back", S_IRQ, 32'd1, 0);
        rd("t4_mstatus_mret", F_RS, 12'h300, 32'd0, 1'b1, 32'h0000_1888, 1'b0);
        nop();
        trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_0207; trap_tval = 32'd0;
        mret = 1'b1;
        push("t4_mepc", S_MEPC, 32'h0000_0204, 1);
        tick();
        trap_valid = 1'b0;
        mret = 1'b0;
        rd("t4_mstatus_both", F_RS, 12'h300, 32'd0, 1'b1, 32'h0000_1880, 1'b0);
        rd("t4_mcause", F_RS, 12'h342, 32'd0, 1'b1, 32'd2, 1'b0);

        // 64-bit mcycle wrap
        op(F_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        tick();
        rd("t5_mcycleh_old", F_RW, 12'hB80, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        tick();
        rd("t5_lo_ones", F_RS, 12'hB00, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        rd("t5_hi_ones", F_RS, 12'hB80, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        rd("t5_lo_wrap", F_RS, 12'hB00, 32'd0, 1'b1, 32'd0, 1'b0);
        rd("t5_hi_wrap", F_RS, 12'hB80, 32'd0, 1'b1, 32'd0, 1'b0);
        tick();
        rd("t5_lo_one", F_RS, 12'hB00, 32'd0, 1'b1, 32'd1, 1'b0);
        rd("t5_hi_zero", F_RS, 12'hB80, 32'd0, 1'b1, 32'd0, 1'b0);

        // Read-only aliases and minstret
        rd("t6_rc_cycle_z", F_RC, 12'hC00, 32'h0000_00FF, 1'b1, 32'd1, 1'b0);
        rd("t6_rw_cycle", F_RW, 12'hC00, 32'd5, 1'b0, 32'd0, 1'b1);
        rd("t6_rci_instret", F_RCI, 12'hC02, 32'd3, 1'b1, 32'd0, 1'b0);
        nop();
        tick();
        tick();
        rd("t6_minstret_idle", F_RS, 12'hB02, 32'd0, 1'b1, 32'd0, 1'b0);
        instret = 1'b1;
        repeat (3) tick();
        rd("t6_minstret_3", F_RS, 12'hB02, 32'd0, 1'b1, 32'd3, 1'b0);
        rd("t6_minstret_w", F_RW, 12'hB02, 32'h0000_0010, 1'b0, 32'd3, 1'b0);
        tick();
        rd("t6_minstret_nowinc", F_RS, 12'hB02, 32'd0, 1'b1, 32'h0000_0010, 1'b0);
        tick();
        instret = 1'b0;
        rd("t6_minstret_inc", F_RS, 12'hB02, 32'd0, 1'b1, 32'h0000_0011, 1'b0);
        rd("t6_minstreth", F_RS, 12'hB82, 32'd0, 1'b1, 32'd0, 1'b0);
        nop();
        tick();

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
